cci_burst_copy_engine: RTL

// Parametrised CCI-P copy/stream engine that sits between the app CSR block and the MPF shim.

---
 rtl/cci_burst_copy_engine.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/cci_burst_copy_engine.sv
// CCI-P burst copy engine: reads source lines in 1/2/4-line bursts under a credit limit,
// writes each returned line to the matching destination offset, then posts a status line.
module cci_burst_copy_engine #(
    parameter int unsigned ADDR_W          = 42,
    parameter int unsigned DATA_W          = 512,
    parameter int unsigned TAG_W           = 16,
    parameter int unsigned MAX_OUTSTANDING = 64
) (
    input  logic              clk,
    input  logic              Resetb,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] status_addr,
    input  logic [31:0]       num_lines,
    input  logic [1:0]        burst_sel,
    input  logic              c0_almfull,
    input  logic              c1_almfull,
    output logic              rd_req_valid,
    output logic [ADDR_W-1:0] rd_req_addr,
    output logic [1:0]        rd_req_len,
    output logic [TAG_W-1:0]  rd_req_tag,
    input  logic              rd_rsp_valid,
    input  logic [TAG_W-1:0]  rd_rsp_tag,
    input  logic [1:0]        rd_rsp_cl_num,
    input  logic [DATA_W-1:0] rd_rsp_data,
    output logic              wr_req_valid,
    output logic [ADDR_W-1:0] wr_req_addr,
    output logic [DATA_W-1:0] wr_req_data,
    input  logic              wr_rsp_valid,
    input  logic              wr_rsp_format,
    input  logic [1:0]        wr_rsp_cl_num,
    output logic              busy,
    output logic              done,
    output logic [63:0]       clk_cnt,
    output logic [31:0]       lines_read,
    output logic [31:0]       lines_written
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 4) + 1;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StWait   = 2'd2;
    localparam logic [1:0] StReport = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] stat_q, stat_d;
    logic [31:0]       num_q, num_d;
    logic [2:0]        burst_q, burst_d;
    logic [OUT_W-1:0]  outst_q, outst_d;
    logic [31:0]       lines_read_q, lines_read_d;
    logic [31:0]       lines_written_q, lines_written_d;
    logic [63:0]       clk_cnt_q, clk_cnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]        rd_len_q, rd_len_d;
    logic [TAG_W-1:0]  rd_tag_q, rd_tag_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              done_q, done_d;

    logic              active;
    logic              issue;
    logic [31:0]       remaining;
    logic [2:0]        step;
    logic [TAG_W-1:0]  tag_delta;
    logic [31:0]       rsp_idx;
    logic [31:0]       wr_inc;
    logic [DATA_W-1:0] status_line;

    assign active    = (state_q == StRun) || (state_q == StWait);
    assign remaining = num_q - lines_read_q;
    // Tail shorter than a full burst goes out one line at a time.
    assign step      = (remaining < 32'(burst_q)) ? 3'd1 : burst_q;
    assign issue     = (state_q == StRun) && (lines_read_q != num_q) && !c0_almfull
                       && !c1_almfull && (32'(outst_q) + 32'(step) <= MAX_OUTSTANDING);

    // The tag carries only the low bits of the burst's first line; the credit bound keeps the
    // distance to the current read pointer below 2**TAG_W, so the full index is recoverable.
    assign tag_delta = lines_read_q[TAG_W-1:0] - rd_rsp_tag;
    assign rsp_idx   = lines_read_q - 32'(tag_delta) + 32'(rd_rsp_cl_num);
    assign wr_inc    = wr_rsp_format ? (32'(wr_rsp_cl_num) + 32'd1) : 32'd1;

    always_comb begin
        status_line          = '0;
        status_line[0]       = 1'b1;
        status_line[127:64]  = clk_cnt_q;
        status_line[159:128] = lines_read_q;
        status_line[191:160] = lines_written_q;
    end

    always_comb begin
        state_d         = state_q;
        src_d           = src_q;
        dst_d           = dst_q;
        stat_d          = stat_q;
        num_d           = num_q;
        burst_d         = burst_q;
        outst_d         = outst_q;
        lines_read_d    = lines_read_q;
        lines_written_d = lines_written_q;
        clk_cnt_d       = clk_cnt_q;
        rd_valid_d      = 1'b0;
        rd_addr_d       = rd_addr_q;
        rd_len_d        = rd_len_q;
        rd_tag_d        = rd_tag_q;
        wr_valid_d      = 1'b0;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        done_d          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && (num_lines != 32'd0)) begin
                    src_d           = src_base;
                    dst_d           = dst_base;
                    stat_d          = status_addr;
                    num_d           = num_lines;
                    burst_d         = (burst_sel == 2'd0) ? 3'd1 :
                                      (burst_sel == 2'd1) ? 3'd2 : 3'd4;
                    outst_d         = '0;
                    lines_read_d    = '0;
                    lines_written_d = '0;
                    clk_cnt_d       = '0;
                    state_d         = StRun;
                end
            end
            StRun: begin
                if (lines_read_q == num_q) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (lines_written_q == num_q) begin
                    state_d = StReport;
                end
            end
            StReport: begin
                if (!c1_almfull) begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = stat_q;
                    wr_data_d  = status_line;
                    done_d     = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (active) begin
            clk_cnt_d = clk_cnt_q + 64'd1;
            if (wr_rsp_valid) begin
                lines_written_d = lines_written_q + wr_inc;
            end
            if (rd_rsp_valid) begin
                wr_valid_d = 1'b1;
                wr_addr_d  = dst_q + ADDR_W'(rsp_idx);
                wr_data_d  = rd_rsp_data;
                outst_d    = outst_d - OUT_W'(1);
            end
        end

        if (issue) begin
            rd_valid_d   = 1'b1;
            rd_addr_d    = src_q + ADDR_W'(lines_read_q);
            rd_len_d     = (step == 3'd4) ? 2'd3 : (step == 3'd2) ? 2'd1 : 2'd0;
            rd_tag_d     = lines_read_q[TAG_W-1:0];
            lines_read_d = lines_read_q + 32'(step);
            outst_d      = outst_d + OUT_W'(step);
        end
    end

    always_ff @(posedge clk or negedge Resetb) begin
        if (!Resetb) begin
            state_q         <= StIdle;
            src_q           <= '0;
            dst_q           <= '0;
            stat_q          <= '0;
            num_q           <= '0;
            burst_q         <= '0;
            outst_q         <= '0;
            lines_read_q    <= '0;
            lines_written_q <= '0;
            clk_cnt_q       <= '0;
            rd_valid_q      <= 1'b0;
            rd_addr_q       <= '0;
            rd_len_q        <= '0;
            rd_tag_q        <= '0;
            wr_valid_q      <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            src_q           <= src_d;
            dst_q           <= dst_d;
            stat_q          <= stat_d;
            num_q           <= num_d;
            burst_q         <= burst_d;
            outst_q         <= outst_d;
            lines_read_q    <= lines_read_d;
            lines_written_q <= lines_written_d;
            clk_cnt_q       <= clk_cnt_d;
            rd_valid_q      <= rd_valid_d;
            rd_addr_q       <= rd_addr_d;
            rd_len_q        <= rd_len_d;
            rd_tag_q        <= rd_tag_d;
            wr_valid_q      <= wr_valid_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            done_q          <= done_d;
        end
    end

    assign rd_req_valid  = rd_valid_q;
    assign rd_req_addr   = rd_addr_q;
    assign rd_req_len    = rd_len_q;
    assign rd_req_tag    = rd_tag_q;
    assign wr_req_valid  = wr_valid_q;
    assign wr_req_addr   = wr_addr_q;
    assign wr_req_data   = wr_data_q;
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign clk_cnt       = clk_cnt_q;
    assign lines_read    = lines_read_q;
    assign lines_written = lines_written_q;

endmodule
